fifo_entrada: RTL and testbench
===============================

FIFO_ENTRADA -- requirements
Module: fifo_entrada

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the 2-bit destination.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, pointer width; depth = 2**ADDR_WIDTH (default 8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  write request for data_in.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  write word.
REQ-007 SHALL have port pop  input  1  read request, driven by the downstream arbiter.
REQ-008 SHALL have port umbral_af  input  ADDR_WIDTH+1  almost-full threshold.
REQ-009 SHALL have port umbral_ae  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered read word.
REQ-011 SHALL have port valid_out  output  1  data_out holds a word popped on the previous cycle.
REQ-012 SHALL have port dest  output  2  data_out[DATA_WIDTH-1:DATA_WIDTH-2], for the arbiter push decode.
REQ-013 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  occupancy flags.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
REQ-015 SHALL have port error  output  1  sticky overflow/underflow indicator.

Function
REQ-016 Push accepted when push=1 and (full=0 or pop accepted in the same cycle); the word is written at wr_ptr, and wr_ptr increments modulo depth.
REQ-017 Pop accepted when pop=1 and empty=0; the word at rd_ptr loads into data_out on that edge, valid_out=1 for the next cycle, and rd_ptr increments modulo depth.
REQ-018 Read latency SHALL be exactly 1 cycle from the pop edge to data_out/valid_out; with no accepted pop, valid_out=0 and data_out holds its last value.
REQ-019 count SHALL increment on push-only, decrement on pop-only, and stay unchanged when both are accepted.
REQ-020 Flags SHALL be combinational from the registered count: empty=(count==0); full=(count==depth); almost_full=(count>=umbral_af); almost_empty=(count<=umbral_ae).
REQ-021 Push with full=1 and no accepted pop SHALL drop the word, leave the pointers unchanged, and set error.
REQ-022 Pop with empty=1 SHALL be ignored (valid_out=0, pointers unchanged) and SHALL set error.
REQ-023 Push and pop together while empty SHALL accept the push only, with no bypass to data_out; the ignored pop sets error.
REQ-024 Push and pop together while full SHALL accept both; count stays at depth and error is not set.
REQ-025 Pointer wrap from depth-1 to 0 SHALL be seamless; data order is strictly FIFO across the wrap.
REQ-026 error, once set, SHALL remain 1 until reset.
REQ-027 Threshold changes SHALL take effect on flags immediately (combinational); no state is affected.

Reset
REQ-028 reset_L=0 SHALL asynchronously clear wr_ptr, rd_ptr, count, data_out, valid_out and error to 0; empty=1, full=0.
REQ-029 Memory contents SHALL NOT require reset; words in flight are discarded when reset is asserted mid-operation.
REQ-030 The first accepted push/pop SHALL occur on the first rising edge of clk with reset_L=1.

Structure
REQ-031 Depth/width defaults and the dest bit-field position SHALL live in the shared project defines include, also used by the arbiters.
REQ-032 Storage SHALL be a sub-module memoria_fifo (synchronous write, registered read at a given address); the pointer, count and flag logic stays in fifo_entrada.

Verification
REQ-033 Reset, then push 0x11,0x52,0xA3 and pop 3 times -> data_out 0x11,0x52,0xA3 each 1 cycle after its pop, dest 0,1,2; empty=1 at the end.
REQ-034 Push 8 words -> full=1, count=8; 9th push alone -> word dropped, error=1, subsequent pops return the original 8 in order.
REQ-035 umbral_af=6, umbral_ae=1: push 6 -> almost_full rises after the 6th push edge; pop 5 -> almost_empty=1 with count=1.
REQ-036 Pop while empty after reset -> valid_out=0, error=1; simultaneous push+pop while empty -> count=1, valid_out=0.
REQ-037 Full FIFO with push+pop in the same cycle -> count stays 8, error=0, the oldest word appears on data_out; run 20 mixed ops across the pointer wrap -> order preserved.
REQ-038 Assert reset_L mid-stream with count=5 -> count=0, valid_out=0, error=0, empty=1 immediately, without a clock edge.

Source files
------------

// File: rtl/fifo_entrada_pkg.sv
// Shared project defines for the input FIFOs and the arbiters that read them:
// default geometry and where the destination field sits inside a word.
package fifo_entrada_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEST_WIDTH         = 2;

    // Destination lives in the top DEST_WIDTH bits of every word.
    function automatic int dest_lsb(input int data_width);
        return data_width - DEST_WIDTH;
    endfunction

endpackage

// File: rtl/memoria_fifo.sv
// Storage array for fifo_entrada: synchronous write, registered read at a given address.
module memoria_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its word until the next read; a same-address write
    // on the same edge returns the old word, which the full push+pop case needs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_entrada.sv
// Input FIFO in front of the arbiters: pointers, occupancy count, threshold
// flags and a sticky overflow/underflow error around a memoria_fifo array.
module fifo_entrada
    import fifo_entrada_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            dest,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(2**ADDR_WIDTH);
    localparam int                  DLSB  = dest_lsb(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // A pop on an empty FIFO is never accepted, so push+pop while empty is push-only.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH);
    assign almost_full  = (count >= umbral_af);
    assign almost_empty = (count <= umbral_ae);
    assign dest         = data_out[DLSB +: DEST_WIDTH];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if ((push && !push_ok) || (pop && empty)) begin
                error <= 1'b1;
            end
        end
    end

    memoria_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_memoria (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_entrada.sv
// Directed + randomized bench for fifo_entrada against a queue-based model.
module tb_fifo_entrada;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [AW:0]   umbral_af = 4'd7;
    logic [AW:0]   umbral_ae = 4'd1;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    dest;
    logic          empty, full, almost_empty, almost_full;
    logic [AW:0]   count;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0;
    logic          exp_err = 1'b0;

    fifo_entrada #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .dest         (dest),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the queue model says.
    task automatic checkAll();
        int n;
        n = model_q.size();
        checkOutput("count",        32'(count),        32'(n));
        checkOutput("empty",        32'(empty),        32'(n == 0));
        checkOutput("full",         32'(full),         32'(n == DEPTH));
        checkOutput("almost_full",  32'(almost_full),  32'(n >= int'(umbral_af)));
        checkOutput("almost_empty", 32'(almost_empty), 32'(n <= int'(umbral_ae)));
        checkOutput("valid_out",    32'(valid_out),    32'(exp_valid));
        checkOutput("data_out",     32'(data_out),     32'(exp_data));
        checkOutput("dest",         32'(dest),         32'(exp_data[DW-1:DW-2]));
        checkOutput("error",        32'(error),        32'(exp_err));
    endtask

    // One clock of stimulus; the model applies the same request to its queue.
    task automatic applyStimulus(input logic p, input logic [DW-1:0] d, input logic r);
        bit was_full, pop_ok, push_ok;
        @(negedge clk);
        push = p; data_in = d; pop = r;
        @(posedge clk);
        was_full = (model_q.size() == DEPTH);
        pop_ok   = r && (model_q.size() != 0);
        push_ok  = p && (!was_full || pop_ok);
        if (r && !pop_ok) exp_err = 1'b1;
        if (p && !push_ok) exp_err = 1'b1;
        exp_valid = pop_ok;
        if (pop_ok) exp_data = model_q.pop_front();
        if (push_ok) model_q.push_back(d);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        #2;
        reset_L = 1'b0;
        model_q.delete();
        exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
        #1;
        checkAll();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #3;
        checkAll();
        @(negedge clk);
        reset_L = 1'b1;

        // Three words with destinations 0,1,2, then drained in order
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h52, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("first_word", 32'(data_out), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("second_dest", 32'(dest), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("third_dest", 32'(dest), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("hold_data", 32'(data_out), 32'hA3);

        // Threshold behaviour, including a live threshold change
        @(negedge clk);
        umbral_af = 4'd6; umbral_ae = 4'd1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ae_at_one", 32'(almost_empty), 32'd1);
        umbral_ae = 4'd0;
        #1;
        checkAll();
        umbral_ae = 4'd1;
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Fill, then push+pop while full, then mixed traffic across the wrap
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'($urandom), 1'b1);
        checkOutput("full_pushpop_err", 32'(error), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Overflow: ninth push dropped, original eight come back in order
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("overflow_err", 32'(error), 32'd1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Underflow, then push+pop while empty is push-only
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h7C, 1'b1);
        checkOutput("empty_pushpop_cnt", 32'(count), 32'd1);

        // Mid-stream asynchronous reset with five words stored
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'($urandom), 1'b0);
        checkOutput("pre_reset_cnt", 32'(count), 32'd5);
        doReset();
        applyStimulus(1'b1, 8'h3D, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
